// File: rtl/mips_pipeline_pkg.sv
// Shared definitions for the MIPS pipeline EX/MEM slice: ALU status bit
// indices and the layout of a buffered EX/MEM entry.
package mips_pipeline_pkg;

    localparam int ALU_STATUS_W = 4;
    localparam int ZERO         = 0;
    localparam int NEGATIVE     = 1;
    localparam int OVERFLOW     = 2;
    localparam int CARRY        = 3;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    // Reference layout at the default widths; the stage declares the same
    // layout locally so it can follow its own DATA_W / REG_ADDR_W.
    typedef struct packed {
        logic                      trap;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
        logic [DEF_REG_ADDR_W-1:0] write_reg;
        logic [ALU_STATUS_W-1:0]   alu_status;
        logic [DEF_DATA_W-1:0]     alu_result;
        logic [DEF_DATA_W-1:0]     store_data;
        logic [DEF_DATA_W-1:0]     pc;
    } exmem_entry_t;

    function automatic int exmem_entry_w(input int data_w, input int reg_addr_w);
        return 4 + reg_addr_w + ALU_STATUS_W + 3 * data_w;
    endfunction

endpackage

// File: rtl/mips_pipeline_exmem_stage_if.sv
// EX -> EX/MEM -> MEM bus. Both sides use valid/ready: a transfer happens on a
// rising clock edge where valid and ready are both high; valid must not depend on ready.
interface mips_pipeline_exmem_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    import mips_pipeline_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_aluResult;
    logic [ALU_STATUS_W-1:0] in_aluStatus;
    logic                    in_regWrite;
    logic                    in_memRead;
    logic                    in_memWrite;
    logic [REG_ADDR_W-1:0]   in_writeReg;
    logic [DATA_W-1:0]       in_storeData;
    logic [DATA_W-1:0]       in_pc;
    logic                    in_trapEn;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_aluResult;
    logic [ALU_STATUS_W-1:0] out_aluStatus;
    logic                    out_regWrite;
    logic                    out_memRead;
    logic                    out_memWrite;
    logic [REG_ADDR_W-1:0]   out_writeReg;
    logic [DATA_W-1:0]       out_storeData;
    logic [DATA_W-1:0]       out_pc;
    logic                    out_trap;

    logic                    fwd_valid;
    logic [REG_ADDR_W-1:0]   fwd_reg;
    logic [DATA_W-1:0]       fwd_data;

    modport master (
        output in_valid, in_aluResult, in_aluStatus, in_regWrite, in_memRead,
               in_memWrite, in_writeReg, in_storeData, in_pc, in_trapEn, out_ready,
        input  in_ready, out_valid, out_aluResult, out_aluStatus, out_regWrite,
               out_memRead, out_memWrite, out_writeReg, out_storeData, out_pc,
               out_trap, fwd_valid, fwd_reg, fwd_data
    );

    modport slave (
        input  in_valid, in_aluResult, in_aluStatus, in_regWrite, in_memRead,
               in_memWrite, in_writeReg, in_storeData, in_pc, in_trapEn, out_ready,
        output in_ready, out_valid, out_aluResult, out_aluStatus, out_regWrite,
               out_memRead, out_memWrite, out_writeReg, out_storeData, out_pc,
               out_trap, fwd_valid, fwd_reg, fwd_data
    );

endinterface

// File: rtl/mips_pipeline_exmem_buffer.sv
// Generic DEPTH-entry in-order ring buffer with valid/ready on both sides,
// synchronous flush, and a read tap on the most recently written entry.
module mips_pipeline_exmem_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] young_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] young_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             in_ready_q;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A flush squashes the incoming entry; a pop in the same cycle still counts.
    assign push      = in_valid && in_ready_q && !flush;
    assign pop       = out_valid && out_ready;
    assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
    assign young_ptr = (tail_q == '0) ? LAST : tail_q - PTR_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[tail_q] <= in_data;
                tail_q      <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            count_q    <= count_nxt;
            in_ready_q <= (count_nxt < FULL);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (count_q != '0);
    assign out_data   = mem[head_q];
    assign young_data = mem[young_ptr];

endmodule

// File: rtl/mips_pipeline_exmem_stage.sv
// EX/MEM pipeline boundary: in-order buffer, overflow-trap masking and the
// forwarding tap. Optional trap handling is enabled by MIPS_PIPELINE_EXMEM_TRAP_EN.
module mips_pipeline_exmem_stage
    import mips_pipeline_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input logic                          clock,
    input logic                          reset,
    input logic                          flush,
    mips_pipeline_exmem_stage_if.slave   bus
);
    typedef struct packed {
        logic                    trap;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic [REG_ADDR_W-1:0]   write_reg;
        logic [ALU_STATUS_W-1:0] alu_status;
        logic [DATA_W-1:0]       alu_result;
        logic [DATA_W-1:0]       store_data;
        logic [DATA_W-1:0]       pc;
    } entry_t;

    localparam int ENTRY_W = exmem_entry_w(DATA_W, REG_ADDR_W);

    entry_t in_entry;
    entry_t head;
    entry_t young;
    logic   trap_hit;
    logic   buf_out_valid;

`ifdef MIPS_PIPELINE_EXMEM_TRAP_EN
    assign trap_hit = bus.in_trapEn && bus.in_aluStatus[OVERFLOW];
`else
    logic unused_trap_en;
    assign trap_hit       = 1'b0;
    assign unused_trap_en = bus.in_trapEn;
`endif

    // A trapping instruction must not write anything, so its controls are
    // cleared before it is stored; this also keeps it off the forwarding tap.
    always_comb begin
        in_entry            = '0;
        in_entry.trap       = trap_hit;
        in_entry.reg_write  = bus.in_regWrite && !trap_hit;
        in_entry.mem_read   = bus.in_memRead && !trap_hit;
        in_entry.mem_write  = bus.in_memWrite && !trap_hit;
        in_entry.write_reg  = bus.in_writeReg;
        in_entry.alu_status = bus.in_aluStatus;
        in_entry.alu_result = bus.in_aluResult;
        in_entry.store_data = bus.in_storeData;
        in_entry.pc         = bus.in_pc;
    end

    mips_pipeline_exmem_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (bus.in_valid),
        .in_ready   (bus.in_ready),
        .in_data    (in_entry),
        .out_valid  (buf_out_valid),
        .out_ready  (bus.out_ready),
        .out_data   (head),
        .young_data (young)
    );

    assign bus.out_valid     = buf_out_valid;
    assign bus.out_aluResult = head.alu_result;
    assign bus.out_aluStatus = head.alu_status;
    assign bus.out_regWrite  = head.reg_write;
    assign bus.out_memRead   = head.mem_read;
    assign bus.out_memWrite  = head.mem_write;
    assign bus.out_writeReg  = head.write_reg;
    assign bus.out_storeData = head.store_data;
    assign bus.out_pc        = head.pc;
    assign bus.out_trap      = head.trap;

    assign bus.fwd_valid = buf_out_valid && young.reg_write && (young.write_reg != '0);
    assign bus.fwd_reg   = young.write_reg;
    assign bus.fwd_data  = young.alu_result;

    logic unused_young;
    assign unused_young = ^{young.trap, young.mem_read, young.mem_write,
                            young.alu_status, young.store_data, young.pc};

endmodule

// File: tb/tb_mips_pipeline_exmem_stage.sv
// Bench for mips_pipeline_exmem_stage: a DEPTH=2 and a DEPTH=3 instance,
// each with an expected queue drained by a monitor at the falling edge.
module tb_mips_pipeline_exmem_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int EW = 1 + 3 + RW + 4 + 3 * DW;

`ifdef MIPS_PIPELINE_EXMEM_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_a, rst_b, flush_a, flush_b;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];

  mips_pipeline_exmem_stage_if #(.DATA_W(DW), .REG_ADDR_W(RW)) bus_a ();
  mips_pipeline_exmem_stage_if #(.DATA_W(DW), .REG_ADDR_W(RW)) bus_b ();

  mips_pipeline_exmem_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .DEPTH(2)) dut_a (
    .clock (clock), .reset (rst_a), .flush (flush_a), .bus (bus_a.slave)
  );
  mips_pipeline_exmem_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .DEPTH(3)) dut_b (
    .clock (clock), .reset (rst_b), .flush (flush_b), .bus (bus_b.slave)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // expected model of what the stage should present for one pushed entry
  function automatic logic [EW-1:0] model(input logic [DW-1:0] alu, input logic [3:0] st,
                                          input logic rw, input logic mr, input logic mw,
                                          input logic [RW-1:0] wr, input logic te);
    logic trap;
    trap = TRAP_BUILD && te && st[2];
    return {trap, rw & ~trap, mr & ~trap, mw & ~trap, wr, st, alu, ~alu, {alu[29:0], 2'b00}};
  endfunction

  function automatic logic [EW-1:0] pack_a();
    return {bus_a.out_trap, bus_a.out_regWrite, bus_a.out_memRead, bus_a.out_memWrite,
            bus_a.out_writeReg, bus_a.out_aluStatus, bus_a.out_aluResult,
            bus_a.out_storeData, bus_a.out_pc};
  endfunction

  function automatic logic [EW-1:0] pack_b();
    return {bus_b.out_trap, bus_b.out_regWrite, bus_b.out_memRead, bus_b.out_memWrite,
            bus_b.out_writeReg, bus_b.out_aluStatus, bus_b.out_aluResult,
            bus_b.out_storeData, bus_b.out_pc};
  endfunction

  // driver tasks
  task automatic drive_a(input logic [DW-1:0] alu, input logic [3:0] st, input logic rw,
                         input logic mr, input logic mw, input logic [RW-1:0] wr, input logic te);
    bus_a.in_aluResult = alu;
    bus_a.in_aluStatus = st;
    bus_a.in_regWrite  = rw;
    bus_a.in_memRead   = mr;
    bus_a.in_memWrite  = mw;
    bus_a.in_writeReg  = wr;
    bus_a.in_storeData = ~alu;
    bus_a.in_pc        = {alu[29:0], 2'b00};
    bus_a.in_trapEn    = te;
  endtask

  task automatic drive_b(input logic [DW-1:0] alu, input logic [RW-1:0] wr);
    bus_b.in_aluResult = alu;
    bus_b.in_aluStatus = 4'b0000;
    bus_b.in_regWrite  = 1'b1;
    bus_b.in_memRead   = alu[0];
    bus_b.in_memWrite  = alu[1];
    bus_b.in_writeReg  = wr;
    bus_b.in_storeData = ~alu;
    bus_b.in_pc        = {alu[29:0], 2'b00};
    bus_b.in_trapEn    = 1'b0;
  endtask

  // called at posedge+1; returns at posedge+1 after the entry was accepted
  task automatic send_a(input logic [DW-1:0] alu, input logic [3:0] st, input logic rw,
                        input logic mr, input logic mw, input logic [RW-1:0] wr, input logic te);
    int waits;
    waits = 0;
    drive_a(alu, st, rw, mr, mw, wr, te);
    bus_a.in_valid = 1'b1;
    while (!bus_a.in_ready && waits < 20) begin
      @(posedge clock); #1;
      waits++;
    end
    if (!bus_a.in_ready) begin
      chk("a_send_timeout", 1, 0);
    end else begin
      exp_a.push_back(model(alu, st, rw, mr, mw, wr, te));
      @(posedge clock); #1;
    end
    bus_a.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // stimulus, with the scoreboard monitor forked alongside
  initial begin
    int pushes, cyc;
    logic v;
    logic [DW-1:0] d;

    rst_a = 1'b1; rst_b = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    drive_a('0, 4'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive_b('0, '0);

    fork
      forever begin
        @(negedge clock);
        if (!rst_a && bus_a.out_valid && bus_a.out_ready) begin
          if (exp_a.size() == 0) chk("a_unexpected_pop", 1, 0);
          else chk("a_head", pack_a(), exp_a.pop_front());
        end
        if (!rst_b && bus_b.out_valid && bus_b.out_ready) begin
          if (exp_b.size() == 0) chk("b_unexpected_pop", 1, 0);
          else chk("b_head", pack_b(), exp_b.pop_front());
        end
      end
    join_none

    // reset state
    idle(3);
    chk("a_rst_out_valid", bus_a.out_valid, 0);
    chk("a_rst_in_ready", bus_a.in_ready, 1);
    chk("a_rst_out_fields", pack_a(), 0);
    chk("a_rst_fwd_valid", bus_a.fwd_valid, 0);
    chk("a_rst_fwd_reg", bus_a.fwd_reg, 0);
    chk("a_rst_fwd_data", bus_a.fwd_data, 0);
    chk("b_rst_in_ready", bus_b.in_ready, 1);
    rst_a = 1'b0; rst_b = 1'b0;
    idle(1);

    // back-to-back 0x11, 0x22, 0x33 with MEM always ready
    bus_a.out_ready = 1'b1;
    drive_a(32'h11, 4'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0);
    chk("a_no_bypass", bus_a.out_valid, 0);
    send_a(32'h11, 4'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0);
    chk("a_latency_valid", bus_a.out_valid, 1);
    chk("a_ready_1", bus_a.in_ready, 1);
    send_a(32'h22, 4'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0);
    chk("a_ready_2", bus_a.in_ready, 1);
    send_a(32'h33, 4'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0);
    chk("a_ready_3", bus_a.in_ready, 1);
    idle(2);
    chk("a_drained_1", bus_a.out_valid, 0);

    // fill, hold off a third entry, release
    bus_a.out_ready = 1'b0;
    send_a(32'hA0, 4'b0001, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0);
    send_a(32'hA1, 4'b1000, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
    chk("a_full_in_ready", bus_a.in_ready, 0);
    chk("a_full_head", bus_a.out_aluResult, 32'hA0);
    fork
      send_a(32'hA2, 4'b0010, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0);
      begin
        repeat (2) @(posedge clock);
        #1 bus_a.out_ready = 1'b1;
        @(posedge clock); #1;
        chk("a_ready_after_pop", bus_a.in_ready, 1);
      end
    join
    idle(3);
    chk("a_drained_2", bus_a.out_valid, 0);
    chk("a_queue_empty_2", exp_a.size(), 0);

    // forwarding tap
    bus_a.out_ready = 1'b0;
    send_a(32'h50, 4'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("a_fwd_r0_valid", bus_a.fwd_valid, 0);
    send_a(32'hDEAD, 4'b0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0);
    chk("a_fwd_valid", bus_a.fwd_valid, 1);
    chk("a_fwd_reg", bus_a.fwd_reg, 5);
    chk("a_fwd_data", bus_a.fwd_data, 32'hDEAD);

    // flush with two entries buffered and in_valid high
    drive_a(32'hBAD, 4'b0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0);
    bus_a.in_valid = 1'b1; flush_a = 1'b1;
    @(posedge clock); #1;
    bus_a.in_valid = 1'b0; flush_a = 1'b0;
    exp_a.delete();
    chk("a_flush_out_valid", bus_a.out_valid, 0);
    chk("a_flush_in_ready", bus_a.in_ready, 1);
    chk("a_flush_fwd_valid", bus_a.fwd_valid, 0);

    // flush while popping and pushing: pop honoured, push dropped
    send_a(32'h77, 4'b0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0);
    drive_a(32'hBAE, 4'b0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0);
    bus_a.out_ready = 1'b1; bus_a.in_valid = 1'b1; flush_a = 1'b1;
    @(posedge clock); #1;
    bus_a.in_valid = 1'b0; flush_a = 1'b0;
    chk("a_flush_pop_seen", exp_a.size(), 0);
    exp_a.delete();
    chk("a_flush2_out_valid", bus_a.out_valid, 0);
    idle(3);

    // overflow trap
    bus_a.out_ready = 1'b0;
    send_a(32'h7FFF_FFFF, 4'b0100, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
    chk("a_trap_out_trap", bus_a.out_trap, TRAP_BUILD);
    chk("a_trap_regwrite", bus_a.out_regWrite, !TRAP_BUILD);
    chk("a_trap_memwrite", bus_a.out_memWrite, !TRAP_BUILD);
    chk("a_trap_fwd_valid", bus_a.fwd_valid, !TRAP_BUILD);
    bus_a.out_ready = 1'b1;
    idle(2);
    send_a(32'h8000_0000, 4'b0100, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0);
    chk("a_notrap_te0", bus_a.out_trap, 0);
    chk("a_notrap_te0_fwd", bus_a.fwd_valid, 1);
    send_a(32'h0, 4'b0001, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1);
    chk("a_notrap_noovf", bus_a.out_trap, 0);
    idle(3);
    chk("a_queue_empty_end", exp_a.size(), 0);

    // DEPTH=3 random push/pop, enough pushes to wrap the pointers repeatedly
    pushes = 0; cyc = 0; d = 32'h100;
    while ((cyc < 24 || pushes < 8) && cyc < 200) begin
      v = ($urandom_range(0, 3) != 0);
      bus_b.out_ready = 1'($urandom_range(0, 1));
      drive_b(d, RW'(d[4:0]));
      bus_b.in_valid = v;
      if (v && bus_b.in_ready) begin
        exp_b.push_back(model(d, 4'b0, 1'b1, d[0], d[1], RW'(d[4:0]), 1'b0));
        pushes++;
        d++;
      end
      @(posedge clock); #1;
      cyc++;
    end

    // make sure something is buffered, then reset mid-stream
    bus_b.out_ready = 1'b0;
    drive_b(d, 5'd12);
    bus_b.in_valid = 1'b1;
    if (bus_b.in_ready) begin
      exp_b.push_back(model(d, 4'b0, 1'b1, d[0], d[1], 5'd12, 1'b0));
      d++;
    end
    @(posedge clock); #1;
    chk("b_pre_reset_valid", bus_b.out_valid, 1);
    bus_b.out_ready = 1'b1; rst_b = 1'b1;
    @(posedge clock); #1;
    rst_b = 1'b0; bus_b.in_valid = 1'b0;
    exp_b.delete();
    chk("b_rst_out_valid", bus_b.out_valid, 0);
    chk("b_rst_in_ready2", bus_b.in_ready, 1);
    chk("b_rst_out_fields", pack_b(), 0);
    chk("b_rst_fwd_valid", bus_b.fwd_valid, 0);
    chk("b_rst_fwd_data", bus_b.fwd_data, 0);

    for (int i = 0; i < 10; i++) begin
      v = ($urandom_range(0, 2) != 0);
      bus_b.out_ready = 1'($urandom_range(0, 1));
      drive_b(d, RW'(d[4:0]));
      bus_b.in_valid = v;
      if (v && bus_b.in_ready) begin
        exp_b.push_back(model(d, 4'b0, 1'b1, d[0], d[1], RW'(d[4:0]), 1'b0));
        d++;
      end
      @(posedge clock); #1;
    end
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    idle(6);
    chk("b_drained", bus_b.out_valid, 0);
    chk("b_queue_empty_end", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_pipeline_exmem_stage.md
Name: mips_pipeline_exmem_stage

Overview:
- Registered EX/MEM boundary of the pipelined MIPS core, with a parametrised in-order buffer of DEPTH entries.
- Each accepted EX result (ALU result, ALU status, MEM/WB control, destination register, store data, PC) is captured and held until the MEM stage takes it.
- Valid/ready handshake on both sides, synchronous flush, and a forwarding tap from the youngest buffered producer for the hazard unit.

Parameters:
- DATA_W, 32, width of aluResult, storeData and pc.
- REG_ADDR_W, 5, width of the register-file address.
- DEPTH, 2, number of buffer entries; minimum 1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  EX presents an entry.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- in_aluResult  in  DATA_W  ALU result.
- in_aluStatus  in  4  {carry, overflow, negative, zero}.
- in_regWrite, in_memRead, in_memWrite  in  1 each  control bits.
- in_writeReg  in  REG_ADDR_W  destination register.
- in_storeData  in  DATA_W  rt value for stores.
- in_pc  in  DATA_W  instruction PC.
- in_trapEn  in  1  instruction traps on signed overflow.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM accepts the head.
- out_*  out  same widths as in_*  head entry fields, excluding trapEn.
- out_trap  out  1  head entry raised an overflow trap.
- fwd_valid  out  1  youngest entry writes a non-zero register.
- fwd_reg  out  REG_ADDR_W  youngest entry's writeReg.
- fwd_data  out  DATA_W  youngest entry's aluResult.

Behaviour:
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Circular buffer with head/tail pointers modulo DEPTH and count of width clog2(DEPTH+1).
  - in_ready is a registered signal equal to count < DEPTH, computed from next-state.
  - out_valid = count != 0.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. Sustained throughput is 1/cycle for DEPTH>=2 and 1 per 2 cycles for DEPTH=1.
- Push while full: impossible, because in_ready=0. A pop in the same cycle does not admit a push; in_ready rises the next cycle.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Push into empty with out_ready=1: the entry is not bypassed; it appears the next cycle.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0. Supports non-power-of-2 DEPTH.
- Flush:
  - Next cycle count=0, out_valid=0 and fwd_valid=0.
  - An entry pushed in the flush cycle is discarded, and a pop in that cycle is still honoured by MEM.
  - in_ready=1 after the flush.
- Reset:
  - Same as flush, plus all storage cleared to 0.
  - Outputs after reset: out_valid=0, in_ready=1, all out_* and fwd_* = 0, out_trap=0.
  - Reset mid-operation drops all entries without any pop.
  - Reset has priority over flush, and flush has priority over push.
- Out fields when out_valid=0: they hold the stale head value; the bench checks fields only when out_valid=1.
- Forwarding:
  - Taken from entry (tail-1) when count != 0.
  - fwd_valid = count != 0 && regWrite && writeReg != 0.

Optional Feature:
- MIPS_PIPELINE_EXMEM_TRAP_EN defined:
  - On push with in_trapEn && in_aluStatus[2] (overflow), the stored regWrite, memRead and memWrite are forced to 0 and the trap bit is set to 1.
  - out_trap reflects the head entry's trap bit.
  - A trapped entry never drives fwd_valid.
- Macro undefined: in_trapEn is ignored, out_trap is tied to 0, and control bits are stored unmodified.
- The port list is identical in both builds.

Decomposition:
- Shared package mips_pipeline_pkg holds:
  - AluStatus bit indices: ZERO=0, NEGATIVE=1, OVERFLOW=2, CARRY=3; width 4.
  - The packed ExMem entry typedef, parameterised by DATA_W and REG_ADDR_W.
- One sub-module: mips_pipeline_exmem_buffer, a generic DEPTH-entry valid/ready ring buffer with flush. The stage wraps it with trap masking and the forwarding tap.

Test Plan:
- Reset, then 3 back-to-back pushes (aluResult=0x11,0x22,0x33) with out_ready=1 -> out_valid from cycle 1, outputs 0x11,0x22,0x33 on consecutive cycles, in_ready stays 1.
- DEPTH=2, out_ready=0, push 0xA0,0xA1 -> in_ready=0 after the second push. A third in_valid is held off. Raise out_ready -> 0xA0 pops, in_ready returns 1 the next cycle, and order is preserved.
- Push regWrite=1, writeReg=0 -> fwd_valid=0. Push writeReg=5, aluResult=0xDEAD -> fwd_valid=1, fwd_reg=5, fwd_data=0xDEAD.
- Two entries buffered, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle entry never appears.
- With MIPS_PIPELINE_EXMEM_TRAP_EN: push aluStatus=4'b0100, trapEn=1, regWrite=1, memWrite=1 -> out_trap=1, out_regWrite=0, out_memWrite=0, fwd_valid=0. Without the macro -> out_trap=0 and control passes through.
- DEPTH=3, 10 random push/pop cycles crossing the wrap at least twice, with reset asserted mid-stream -> the scoreboard sees in-order, lossless data before reset and empty outputs right after it.
